// File: rtl/vm_pkg.sv
// Shared types for the multi-product vending controller.
//   coin_e     : coin code used on both the coin slot and the change hopper
//   state_e    : controller state (IDLE, VEND, CHANGE)
//   coin_value : coin code -> value in 10-cent units (0 for none/invalid)
package vm_pkg;

    localparam int VM_COIN_W = 3;

    typedef enum logic [VM_COIN_W-1:0] {
        NONE = 3'd0,
        C1   = 3'd1,
        C2   = 3'd2,
        C5   = 3'd3,
        C10  = 3'd4,
        C20  = 3'd5
    } coin_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_e;

    function automatic logic [4:0] coin_value(input logic [VM_COIN_W-1:0] code);
        logic [4:0] v;
        case (code)
            3'd1:    v = 5'd1;
            3'd2:    v = 5'd2;
            3'd3:    v = 5'd5;
            3'd4:    v = 5'd10;
            3'd5:    v = 5'd20;
            default: v = 5'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vending_ctrl_multi_if.sv
// Front-end / actuator bundle of the vending controller.
//   coin_in, sel_in, cancel_in, refill_in : requests from coin slot and keypad
//   beverage_out, change_out               : dispenser and coin-hopper commands
//   coin_reject, sel_deny                  : one-cycle refusal pulses
//   sold_out, balance_out, busy            : status mirrors
// master = front end / bench side, slave = controller side.
interface vending_ctrl_multi_if #(
    parameter int NUM_PROD = 4,
    parameter int BAL_W    = 7
);
    localparam int SEL_W = $clog2(NUM_PROD + 1);

    logic [vm_pkg::VM_COIN_W-1:0] coin_in;
    logic [SEL_W-1:0]             sel_in;
    logic                         cancel_in;
    logic                         refill_in;
    logic [SEL_W-1:0]             beverage_out;
    logic [vm_pkg::VM_COIN_W-1:0] change_out;
    logic                         coin_reject;
    logic                         sel_deny;
    logic [NUM_PROD-1:0]          sold_out;
    logic [BAL_W-1:0]             balance_out;
    logic                         busy;

    modport master (
        output coin_in, sel_in, cancel_in, refill_in,
        input  beverage_out, change_out, coin_reject, sel_deny, sold_out, balance_out, busy
    );

    modport slave (
        input  coin_in, sel_in, cancel_in, refill_in,
        output beverage_out, change_out, coin_reject, sel_deny, sold_out, balance_out, busy
    );
endinterface

// File: rtl/vm_coin_picker.sv
// Greedy change selector: returns the largest coin (20,10,5,2,1) that does
// not exceed the balance, plus its value. NONE/0 when balance is 0.
//   balance : current credit
//   code    : coin code to emit
//   value   : value of that coin
module vm_coin_picker
    import vm_pkg::*;
#(
    parameter int BAL_W = 7
) (
    input  logic [BAL_W-1:0] balance,
    output coin_e            code,
    output logic [BAL_W-1:0] value
);

    always_comb begin
        code = NONE;
        if      (balance >= BAL_W'(20)) code = C20;
        else if (balance >= BAL_W'(10)) code = C10;
        else if (balance >= BAL_W'(5))  code = C5;
        else if (balance >= BAL_W'(2))  code = C2;
        else if (balance >= BAL_W'(1))  code = C1;
        value = BAL_W'(coin_value(code));
    end

endmodule

// File: rtl/vending_ctrl_multi.sv
// Multi-product vending controller with per-product stock, overflow-safe
// coin acceptance, cancel/refund and greedy one-coin-per-cycle change.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : slave side of vending_ctrl_multi_if (requests in, actuator
//                commands and status out); every output is a register.
module vending_ctrl_multi
    import vm_pkg::*;
#(
    parameter int                        NUM_PROD     = 4,
    parameter int                        BAL_W        = 7,
    parameter int                        MAX_BAL      = 100,
    parameter logic [NUM_PROD*BAL_W-1:0] PRICES       = {7'd12, 7'd8, 7'd5, 7'd3},
    parameter int                        STOCK_W      = 4,
    parameter int                        STOCK_INIT   = 8,
    parameter int                        DISPENSE_CYC = 5
) (
    input logic                 clk,
    input logic                 rst_n,
    vending_ctrl_multi_if.slave bus
);

    localparam int SEL_W = $clog2(NUM_PROD + 1);
    localparam int TMR_W = (DISPENSE_CYC > 1) ? $clog2(DISPENSE_CYC) : 1;

    state_e               state, state_nx;
    logic [BAL_W-1:0]     balance, balance_nx;
    logic [STOCK_W-1:0]   stock [NUM_PROD];
    logic [STOCK_W-1:0]   stock_nx [NUM_PROD];
    logic [TMR_W-1:0]     timer, timer_nx;
    logic [SEL_W-1:0]     bev, bev_nx;
    coin_e                change_q, change_nx;
    logic                 rej, rej_nx, deny, deny_nx, busy_q, busy_nx;
    logic [NUM_PROD-1:0]  sold, sold_nx;

    logic [BAL_W-1:0]     price [NUM_PROD];
    logic                 sel_hit;
    logic [BAL_W-1:0]     sel_price;
    logic [STOCK_W-1:0]   sel_stock;
    coin_e                pick_code;
    logic [BAL_W-1:0]     pick_value;

    for (genvar g = 0; g < NUM_PROD; g++) begin : g_price
        assign price[g] = PRICES[g*BAL_W +: BAL_W];
    end

    vm_coin_picker #(.BAL_W(BAL_W)) u_picker (
        .balance (balance),
        .code    (pick_code),
        .value   (pick_value)
    );

    // Sum is formed one bit wider than the balance so the limit test can
    // never be fooled by wrap-around.
    function automatic logic coin_fits(input logic [BAL_W-1:0] bal,
                                       input logic [VM_COIN_W-1:0] code);
        logic [BAL_W:0] sum;
        sum = {1'b0, bal} + (BAL_W+1)'(coin_value(code));
        return sum <= (BAL_W+1)'(MAX_BAL);
    endfunction

    always_comb begin
        state_nx   = state;
        balance_nx = balance;
        timer_nx   = timer;
        bev_nx     = bev;
        change_nx  = NONE;
        rej_nx     = 1'b0;
        deny_nx    = 1'b0;
        sel_hit    = 1'b0;
        sel_price  = '0;
        sel_stock  = '0;
        for (int k = 0; k < NUM_PROD; k++) begin
            stock_nx[k] = stock[k];
            if (bus.sel_in == SEL_W'(k + 1)) begin
                sel_hit   = 1'b1;
                sel_price = price[k];
                sel_stock = stock[k];
            end
        end

        case (state)
            IDLE: begin
                // Coin beats cancel beats select; a select that loses is
                // silently dropped rather than denied.
                if (bus.coin_in != '0) begin
                    if (bus.coin_in > VM_COIN_W'(C20) || !coin_fits(balance, bus.coin_in))
                        rej_nx = 1'b1;
                    else
                        balance_nx = balance + BAL_W'(coin_value(bus.coin_in));
                end else if (bus.cancel_in) begin
                    if (balance != '0) state_nx = CHANGE;
                end else if (sel_hit) begin
                    if (balance >= sel_price && sel_stock != '0) begin
                        balance_nx = balance - sel_price;
                        state_nx   = VEND;
                        timer_nx   = '0;
                        bev_nx     = bus.sel_in;
                        for (int k = 0; k < NUM_PROD; k++)
                            if (bus.sel_in == SEL_W'(k + 1))
                                stock_nx[k] = stock[k] - STOCK_W'(1);
                    end else begin
                        deny_nx = 1'b1;
                    end
                end
            end
            VEND: begin
                rej_nx = (bus.coin_in != '0);
                if (timer == TMR_W'(DISPENSE_CYC - 1)) begin
                    bev_nx   = '0;
                    state_nx = (balance != '0) ? CHANGE : IDLE;
                end else begin
                    timer_nx = timer + TMR_W'(1);
                end
            end
            CHANGE: begin
                rej_nx = (bus.coin_in != '0);
                if (balance != '0) begin
                    change_nx  = pick_code;
                    balance_nx = balance - pick_value;
                    // Leave on the same edge that pays out the last coin.
                    if (balance == pick_value) state_nx = IDLE;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Refill overrides any decrement made above.
        if (bus.refill_in)
            for (int k = 0; k < NUM_PROD; k++) stock_nx[k] = STOCK_W'(STOCK_INIT);

        for (int k = 0; k < NUM_PROD; k++) sold_nx[k] = (stock_nx[k] == '0);
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            balance  <= '0;
            timer    <= '0;
            bev      <= '0;
            change_q <= NONE;
            rej      <= 1'b0;
            deny     <= 1'b0;
            sold     <= '0;
            busy_q   <= 1'b0;
            for (int k = 0; k < NUM_PROD; k++) stock[k] <= STOCK_W'(STOCK_INIT);
        end else begin
            state    <= state_nx;
            balance  <= balance_nx;
            timer    <= timer_nx;
            bev      <= bev_nx;
            change_q <= change_nx;
            rej      <= rej_nx;
            deny     <= deny_nx;
            sold     <= sold_nx;
            busy_q   <= busy_nx;
            for (int k = 0; k < NUM_PROD; k++) stock[k] <= stock_nx[k];
        end
    end

    assign bus.beverage_out = bev;
    assign bus.change_out   = change_q;
    assign bus.coin_reject  = rej;
    assign bus.sel_deny     = deny;
    assign bus.sold_out     = sold;
    assign bus.balance_out  = balance;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_vending_ctrl_multi.sv
// Bench for vending_ctrl_multi: directed scenarios with literal expectations,
// then random traffic, all outputs compared every cycle with a money/stock
// model of the machine.
module tb_vending_ctrl_multi;

    localparam int NUM_PROD   = 4;
    localparam int BAL_W      = 7;
    localparam int MAX_BAL    = 100;
    localparam int STOCK_INIT = 8;
    localparam int DISP       = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    vending_ctrl_multi_if #(.NUM_PROD(NUM_PROD), .BAL_W(BAL_W)) bus ();

    vending_ctrl_multi #(
        .NUM_PROD(NUM_PROD), .BAL_W(BAL_W), .MAX_BAL(MAX_BAL),
        .STOCK_W(4), .STOCK_INIT(STOCK_INIT), .DISPENSE_CYC(DISP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int PRICE_TAB [NUM_PROD] = '{3, 5, 8, 12};
    int COIN_VAL  [8]        = '{0, 1, 2, 5, 10, 20, 0, 0};
    int DEN       [5]        = '{20, 10, 5, 2, 1};
    int DEN_CODE  [5]        = '{5, 4, 3, 2, 1};

    int m_bal;
    int m_stock [NUM_PROD];
    int m_vend_left;   // dispense cycles still to show
    int m_prod;
    bit m_refunding;
    int m_change;
    int m_rej;
    int m_deny;

    task automatic model_reset();
        m_bal = 0; m_vend_left = 0; m_prod = 0; m_refunding = 0;
        m_change = 0; m_rej = 0; m_deny = 0;
        for (int k = 0; k < NUM_PROD; k++) m_stock[k] = STOCK_INIT;
    endtask

    task automatic model_step();
        int c, s;
        bit busy_now;
        c = int'(bus.coin_in);
        s = int'(bus.sel_in);
        m_rej = 0; m_deny = 0; m_change = 0;
        busy_now = (m_vend_left > 0) || m_refunding;
        if (!busy_now) begin
            if (c != 0) begin
                if (c >= 6 || m_bal + COIN_VAL[c] > MAX_BAL) m_rej = 1;
                else m_bal += COIN_VAL[c];
            end else if (bus.cancel_in) begin
                if (m_bal > 0) m_refunding = 1;
            end else if (s >= 1 && s <= NUM_PROD) begin
                if (m_bal >= PRICE_TAB[s-1] && m_stock[s-1] > 0) begin
                    m_bal -= PRICE_TAB[s-1];
                    m_stock[s-1]--;
                    m_vend_left = DISP;
                    m_prod = s;
                end else begin
                    m_deny = 1;
                end
            end
        end else begin
            m_rej = (c != 0) ? 1 : 0;
            if (m_vend_left > 0) begin
                m_vend_left--;
                if (m_vend_left == 0 && m_bal > 0) m_refunding = 1;
            end else begin
                for (int i = 0; i < 5; i++) begin
                    if (m_change == 0 && DEN[i] <= m_bal) begin
                        m_change = DEN_CODE[i];
                        m_bal -= DEN[i];
                    end
                end
                if (m_bal == 0) m_refunding = 0;
            end
        end
        if (bus.refill_in) for (int k = 0; k < NUM_PROD; k++) m_stock[k] = STOCK_INIT;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    function automatic int m_sold();
        int v = 0;
        for (int k = 0; k < NUM_PROD; k++) if (m_stock[k] == 0) v |= (1 << k);
        return v;
    endfunction

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("beverage_out", int'(bus.beverage_out), (m_vend_left > 0) ? m_prod : 0);
            check("change_out",   int'(bus.change_out),   m_change);
            check("coin_reject",  int'(bus.coin_reject),  m_rej);
            check("sel_deny",     int'(bus.sel_deny),     m_deny);
            check("sold_out",     int'(bus.sold_out),     m_sold());
            check("balance_out",  int'(bus.balance_out),  m_bal);
            check("busy",         int'(bus.busy),         (m_vend_left > 0 || m_refunding) ? 1 : 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int c, input int s, input bit can, input bit rf);
        bus.coin_in   = 3'(c);
        bus.sel_in    = 3'(s);
        bus.cancel_in = can;
        bus.refill_in = rf;
        @(posedge clk);
        #1;
        bus.coin_in   = '0;
        bus.sel_in    = '0;
        bus.cancel_in = 1'b0;
        bus.refill_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " beverage_out"}, int'(bus.beverage_out), 0);
        check({tag, " change_out"},   int'(bus.change_out),   0);
        check({tag, " coin_reject"},  int'(bus.coin_reject),  0);
        check({tag, " sel_deny"},     int'(bus.sel_deny),     0);
        check({tag, " sold_out"},     int'(bus.sold_out),     0);
        check({tag, " balance"},      int'(bus.balance_out),  0);
        check({tag, " busy"},         int'(bus.busy),         0);
    endtask

    initial begin
        bus.coin_in = '0; bus.sel_in = '0; bus.cancel_in = 1'b0; bus.refill_in = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: four 50c coins, buy product 0 (price 3), change 10,5,2
        repeat (4) step(3, 0, 0, 0);
        check("t1 balance 20", int'(bus.balance_out), 20);
        step(0, 1, 0, 0);
        check("t1 bev", int'(bus.beverage_out), 1);
        check("t1 busy", int'(bus.busy), 1);
        check("t1 balance 17", int'(bus.balance_out), 17);
        idle(4);
        check("t1 bev held", int'(bus.beverage_out), 1);
        idle(1);
        check("t1 bev end", int'(bus.beverage_out), 0);
        check("t1 busy in change", int'(bus.busy), 1);
        step(0, 0, 0, 0); check("t1 change 10", int'(bus.change_out), 4);
        step(0, 0, 0, 0); check("t1 change 5",  int'(bus.change_out), 3);
        step(0, 0, 0, 0); check("t1 change 2",  int'(bus.change_out), 2);
        check("t1 idle", int'(bus.busy), 0);
        check("t1 balance 0", int'(bus.balance_out), 0);
        idle(2);

        // 2: fill to 95, +5 -> 100, +1 rejected, cancel -> five 20s
        repeat (4) step(5, 0, 0, 0);
        step(4, 0, 0, 0);
        step(3, 0, 0, 0);
        check("t2 balance 95", int'(bus.balance_out), 95);
        step(3, 0, 0, 0);
        check("t2 balance 100", int'(bus.balance_out), 100);
        step(1, 0, 0, 0);
        check("t2 overflow reject", int'(bus.coin_reject), 1);
        check("t2 balance kept", int'(bus.balance_out), 100);
        step(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0);
            check("t2 refund 20", int'(bus.change_out), 5);
        end
        check("t2 drained", int'(bus.balance_out), 0);
        idle(2);

        // 3: underfunded select, invalid coin
        step(2, 0, 0, 0);
        step(0, 2, 0, 0);
        check("t3 deny", int'(bus.sel_deny), 1);
        check("t3 not busy", int'(bus.busy), 0);
        check("t3 balance 2", int'(bus.balance_out), 2);
        step(7, 0, 0, 0);
        check("t3 invalid reject", int'(bus.coin_reject), 1);
        check("t3 balance still 2", int'(bus.balance_out), 2);
        step(0, 0, 1, 0);
        idle(3);

        // 5: coin wins over select; coin during vend rejected
        step(4, 0, 0, 0);
        step(1, 1, 0, 0);
        check("t5 balance 11", int'(bus.balance_out), 11);
        check("t5 no vend", int'(bus.busy), 0);
        check("t5 no deny", int'(bus.sel_deny), 0);
        step(0, 1, 0, 0);
        step(3, 0, 0, 0);
        check("t5 vend reject", int'(bus.coin_reject), 1);
        check("t5 balance 8", int'(bus.balance_out), 8);
        idle(12);

        // 4: exhaust product 0 (6 left), deny, refill, refill with select
        for (int i = 0; i < 6; i++) begin
            step(4, 0, 0, 0);
            step(0, 1, 0, 0);
            idle(12);
        end
        check("t4 sold_out", int'(bus.sold_out), 1);
        step(4, 0, 0, 0);
        step(0, 1, 0, 0);
        check("t4 deny empty", int'(bus.sel_deny), 1);
        step(0, 0, 0, 1);
        check("t4 refilled", int'(bus.sold_out), 0);
        step(0, 1, 0, 1);
        idle(12);

        // 6: reset during refund of 37
        step(5, 0, 0, 0); step(4, 0, 0, 0); step(3, 0, 0, 0); step(2, 0, 0, 0);
        check("t6 balance 37", int'(bus.balance_out), 37);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        check("t6 first coin", int'(bus.change_out), 5);
        check("t6 balance 17", int'(bus.balance_out), 17);
        #2 rst_n = 1'b0;
        #1 check_all_zero("t6 async reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        check("t6 idle after reset", int'(bus.busy), 0);
        check("t6 balance after reset", int'(bus.balance_out), 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int c, s;
            c = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 7));
            s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 0;
            step(c, s, ($urandom_range(0, 24) == 0), ($urandom_range(0, 59) == 0));
        end
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
